max_pool_fifo: RTL and testbench

MAX_POOL_FIFO -- requirements
Module: max_pool_fifo

---
 rtl/max_pool_fifo.sv | 114 +++++++++++
 tb/tb_max_pool_fifo.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/max_pool_fifo.sv
// max_pool_fifo: 2x2 stride-2 max pooling over a channel-interleaved
// raster stream (channel fastest, then column, then row). With MAX_POOL=0
// the block degenerates to a registered pass-through that still tracks the
// frame position so frame_done marks the last sample of each frame.
module max_pool_fifo #(
    parameter int IN_CHANNELS  = 4,
    parameter int IMAGE_WIDTH  = 128,
    parameter int IMAGE_HEIGHT = 128,
    parameter int DATA_WIDTH   = 16,
    parameter int MAX_POOL     = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [DATA_WIDTH-1:0] output_data_max_fifo,
    input  logic                         max_fifo_en_max_fifo,
    output logic signed [DATA_WIDTH-1:0] output_data_pool,
    output logic                         pool_valid,
    output logic                         frame_done
);

    localparam int HALF_W = IMAGE_WIDTH / 2;
    localparam int CH_W   = (IN_CHANNELS > 1) ? $clog2(IN_CHANNELS) : 1;
    localparam int COL_W  = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
    localparam int ROW_W  = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
    localparam int HCOL_W = (HALF_W > 1) ? $clog2(HALF_W) : 1;

    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(IN_CHANNELS - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMAGE_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMAGE_HEIGHT - 1);

    logic [CH_W-1:0]  ch_cnt;
    logic [COL_W-1:0] col_cnt;
    logic [ROW_W-1:0] row_cnt;

    // Horizontal pair holder (even column) and half-width row buffer that
    // keeps the horizontal max of the even row until the odd row arrives.
    logic signed [DATA_WIDTH-1:0] hreg   [IN_CHANNELS];
    logic signed [DATA_WIDTH-1:0] rowbuf [HALF_W][IN_CHANNELS];

    logic [HCOL_W-1:0]            hcol;
    logic signed [DATA_WIDTH-1:0] h_sel;
    logic signed [DATA_WIDTH-1:0] rb_sel;
    logic signed [DATA_WIDTH-1:0] h_max;
    logic signed [DATA_WIDTH-1:0] pool_max;
    logic                         last_sample;
    logic                         consume;

    assign consume = max_fifo_en_max_fifo;

    // Operand selection and signed max tree for the current sample.
    always_comb begin
        hcol        = HCOL_W'(col_cnt >> 1);
        h_sel       = hreg[ch_cnt];
        rb_sel      = rowbuf[hcol][ch_cnt];
        h_max       = (h_sel > output_data_max_fifo) ? h_sel : output_data_max_fifo;
        pool_max    = (rb_sel > h_max) ? rb_sel : h_max;
        last_sample = (ch_cnt == CH_LAST) && (col_cnt == COL_LAST) && (row_cnt == ROW_LAST);
    end

    // Position counters and the registered output stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            ch_cnt           <= '0;
            col_cnt          <= '0;
            row_cnt          <= '0;
            pool_valid       <= 1'b0;
            frame_done       <= 1'b0;
            output_data_pool <= '0;
        end else begin
            pool_valid <= 1'b0;
            frame_done <= 1'b0;
            if (consume) begin
                if (ch_cnt == CH_LAST) begin
                    ch_cnt <= '0;
                    if (col_cnt == COL_LAST) begin
                        col_cnt <= '0;
                        if (row_cnt == ROW_LAST) begin
                            row_cnt <= '0;
                        end else begin
                            row_cnt <= row_cnt + 1'b1;
                        end
                    end else begin
                        col_cnt <= col_cnt + 1'b1;
                    end
                end else begin
                    ch_cnt <= ch_cnt + 1'b1;
                end

                if (MAX_POOL == 0) begin
                    output_data_pool <= output_data_max_fifo;
                    pool_valid       <= 1'b1;
                    frame_done       <= last_sample;
                end else if (col_cnt[0] && row_cnt[0]) begin
                    output_data_pool <= pool_max;
                    pool_valid       <= 1'b1;
                    frame_done       <= last_sample;
                end
            end
        end
    end

    // Pooling storage; contents are don't-care after reset because every
    // entry is rewritten before it is read within a frame.
    always_ff @(posedge clk) begin
        if (!rst && consume) begin
            if (!col_cnt[0]) begin
                hreg[ch_cnt] <= output_data_max_fifo;
            end else if (!row_cnt[0]) begin
                rowbuf[hcol][ch_cnt] <= h_max;
            end
        end
    end

endmodule

// File: tb/tb_max_pool_fifo.sv
// Scoreboard bench for max_pool_fifo: three instances (1-channel 4x4 pool,
// 2-channel 2x2 pool, 1-channel 2x2 pass-through) share a data bus and reset,
// each with its own enable. Expected outputs come from whole-image windows.
module tb_max_pool_fifo;

    typedef struct {
        int id;
        int v;
        int fd;
        int cyc;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                rst_q = 1'b1;
    logic signed [15:0]  din = '0;
    logic [2:0]          en = '0;
    logic signed [15:0]  ov [3];
    logic                pv [3];
    logic                fdv [3];
    int                  cyc = 0;
    int                  compared = 0;
    int                  mismatched = 0;
    int                  last_v [3] = '{0, 0, 0};
    exp_t                sb [$];

    int cfg_w  [3] = '{4, 2, 2};
    int cfg_h  [3] = '{4, 2, 2};
    int cfg_c  [3] = '{1, 2, 1};
    int cfg_mp [3] = '{1, 1, 0};

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    max_pool_fifo #(.IN_CHANNELS(1), .IMAGE_WIDTH(4), .IMAGE_HEIGHT(4), .DATA_WIDTH(16), .MAX_POOL(1)) dut0 (
        .clk(clk), .rst(rst), .output_data_max_fifo(din), .max_fifo_en_max_fifo(en[0]),
        .output_data_pool(ov[0]), .pool_valid(pv[0]), .frame_done(fdv[0]));

    max_pool_fifo #(.IN_CHANNELS(2), .IMAGE_WIDTH(2), .IMAGE_HEIGHT(2), .DATA_WIDTH(16), .MAX_POOL(1)) dut1 (
        .clk(clk), .rst(rst), .output_data_max_fifo(din), .max_fifo_en_max_fifo(en[1]),
        .output_data_pool(ov[1]), .pool_valid(pv[1]), .frame_done(fdv[1]));

    max_pool_fifo #(.IN_CHANNELS(1), .IMAGE_WIDTH(2), .IMAGE_HEIGHT(2), .DATA_WIDTH(16), .MAX_POOL(0)) dut2 (
        .clk(clk), .rst(rst), .output_data_max_fifo(din), .max_fifo_en_max_fifo(en[2]),
        .output_data_pool(ov[2]), .pool_valid(pv[2]), .frame_done(fdv[2]));

    task automatic chk(input string nm, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int rnd16();
        logic signed [15:0] t;
        t = 16'($urandom);
        return int'(t);
    endfunction

    // Monitor: pops the scoreboard on every valid output; otherwise checks
    // that frame_done stays low and the output holds its previous value.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst_q) begin
                chk($sformatf("rst_data%0d", i), int'(ov[i]), 0);
                chk($sformatf("rst_valid%0d", i), int'(pv[i]), 0);
                chk($sformatf("rst_done%0d", i), int'(fdv[i]), 0);
                last_v[i] = 0;
            end else if (pv[i] === 1'b1) begin
                if (sb.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_out%0d: got value %0d, expected no output", i, ov[i]);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk($sformatf("out_dut%0d", i), i, e.id);
                    chk($sformatf("data%0d", i), int'(ov[i]), e.v);
                    chk($sformatf("frame_done%0d", i), int'(fdv[i]), e.fd);
                    chk($sformatf("latency%0d", i), cyc, e.cyc);
                end
                last_v[i] = int'(ov[i]);
            end else begin
                chk($sformatf("idle_done%0d", i), int'(fdv[i]), 0);
                chk($sformatf("hold%0d", i), int'(ov[i]), last_v[i]);
            end
        end
    end

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            en  = '0;
            din = 16'($urandom);
        end
    endtask

    // Drives the first n samples of img into instance id; each sample that
    // completes a pooling window (or every sample in pass-through) pushes
    // its expected result, computed from the 2D image, one cycle later.
    task automatic send_frame(input int id, input int img[], input int n, input int gapmax);
        int w, c, tot, ch, col, row, v, gap;
        w   = cfg_w[id];
        c   = cfg_c[id];
        tot = w * cfg_h[id] * c;
        for (int k = 0; k < n; k++) begin
            gap = (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0;
            idle_cycles(gap);
            @(posedge clk);
            #1;
            din     = 16'(img[k]);
            en      = '0;
            en[id]  = 1'b1;
            ch  = k % c;
            col = (k / c) % w;
            row = k / (c * w);
            if (cfg_mp[id] == 0) begin
                sb.push_back('{id, img[k], int'(k == tot - 1), cyc + 1});
            end else if ((col % 2 == 1) && (row % 2 == 1)) begin
                v = img[k];
                for (int dr = 0; dr < 2; dr++)
                    for (int dc = 0; dc < 2; dc++)
                        if (img[((row - dr) * w + col - dc) * c + ch] > v)
                            v = img[((row - dr) * w + col - dc) * c + ch];
                sb.push_back('{id, v, int'(k == tot - 1), cyc + 1});
            end
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        en  = '1;
        din = 16'($urandom);
        @(posedge clk);
        #1;
        rst = 1'b0;
        en  = '0;
    endtask

    initial begin
        int img[];
        int img2[];

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // 4x4 ramp 1..16, contiguous
        img = new[16];
        foreach (img[i]) img[i] = i + 1;
        send_frame(0, img, 16, 0);
        idle_cycles(3);

        // 2-channel 2x2 negative values: -2 then 0
        img2 = new[8];
        img2 = '{-5, 0, -3, -1, -7, -8, -2, -9};
        send_frame(1, img2, 8, 0);
        idle_cycles(3);

        // same ramp with random gaps
        send_frame(0, img, 16, 3);
        idle_cycles(3);

        // partial frame, reset (with enables high), then descending frame
        send_frame(0, img, 10, 0);
        idle_cycles(3);
        pulse_reset();
        idle_cycles(1);
        foreach (img[i]) img[i] = 16 - i;
        send_frame(0, img, 16, 0);
        idle_cycles(3);

        // two back-to-back random frames
        for (int f = 0; f < 2; f++) begin
            foreach (img[i]) img[i] = rnd16();
            send_frame(0, img, 16, 0);
        end
        idle_cycles(3);

        // random 2-channel frames with gaps
        for (int f = 0; f < 4; f++) begin
            foreach (img2[i]) img2[i] = rnd16();
            send_frame(1, img2, 8, 2);
        end
        idle_cycles(3);

        // pass-through extremes, then a random frame
        img = new[4];
        img = '{32767, -32768, 5, -1};
        send_frame(2, img, 4, 0);
        foreach (img[i]) img[i] = rnd16();
        send_frame(2, img, 4, 1);
        idle_cycles(5);

        chk("scoreboard_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
